// File: rtl/spram_be_if.sv
// Request/response bundle between a requester and the spram_be RAM.
interface spram_be_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  in_enable;
    logic                  in_write;
    logic [NB-1:0]         in_byte_en;
    logic [ADDR_WIDTH-1:0] in_address;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_busy;

    modport master (
        output in_enable, in_write, in_byte_en, in_address, in_data,
        input  out_data, out_valid, out_busy
    );

    modport slave (
        input  in_enable, in_write, in_byte_en, in_address, in_data,
        output out_data, out_valid, out_busy
    );
endinterface

// File: rtl/spram_be.sv
// Byte-enable single-port RAM with selectable read-during-write and post-reset zero-fill.
// Latency 1+OUT_REG edges; no backpressure, requests are dropped while out_busy is high.
module spram_be #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_WIDTH     = 8,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic        in_clock,
    input logic        in_reset,
    spram_be_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy;
    logic                  accept;
    logic                  clr_we;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] s1_dat;
    logic                  s1_vld;

    assign busy     = (state == CLEAR);
    assign accept   = bus.in_enable & ~busy & ~in_reset;
    assign clr_we   = busy & ~in_reset;
    assign old_word = mem[bus.in_address];

    // Word as it will look after this write, used for write-first output.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.in_byte_en[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.in_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt) begin
                state <= IDLE;
            end
        end
    end

    // Array has no reset; only the clear sequencer zeroes it.
    always_ff @(posedge in_clock) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (accept && bus.in_write) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.in_byte_en[i]) begin
                    mem[bus.in_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.in_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            s1_dat <= '0;
            s1_vld <= 1'b0;
        end else if (!accept) begin
            s1_vld <= 1'b0;
        end else if (!bus.in_write) begin
            s1_dat <= old_word;
            s1_vld <= 1'b1;
        end else if (RDW_MODE == 0) begin
            s1_dat <= old_word;
            s1_vld <= 1'b1;
        end else if (RDW_MODE == 1) begin
            s1_dat <= merged;
            s1_vld <= 1'b1;
        end else begin
            s1_vld <= 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] s2_dat;
            logic                  s2_vld;

            always_ff @(posedge in_clock) begin
                if (in_reset) begin
                    s2_dat <= '0;
                    s2_vld <= 1'b0;
                end else begin
                    s2_dat <= s1_dat;
                    s2_vld <= s1_vld;
                end
            end

            assign bus.out_data  = s2_dat;
            assign bus.out_valid = s2_vld;
        end else begin : g_noreg
            assign bus.out_data  = s1_dat;
            assign bus.out_valid = s1_vld;
        end
    endgenerate

    assign bus.out_busy = busy;
endmodule

// File: tb/tb_spram_be.sv
// Drives three spram_be variants (read-first, write-first, no-change+out-reg) with shared stimulus
// and compares each against a word-level memory model every cycle.
module tb_spram_be;
    localparam int DEPTH = 16;
    localparam int MODE [3] = '{0, 1, 2};
    localparam int OREG [3] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] wdat;

    logic [15:0] obs_dat [3];
    logic        obs_vld [3];
    logic        obs_bsy [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        spram_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8)) bus ();

        assign bus.in_enable  = en;
        assign bus.in_write   = wr;
        assign bus.in_byte_en = be;
        assign bus.in_address = addr;
        assign bus.in_data    = wdat;

        spram_be #(
            .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
            .RDW_MODE(MODE[k]), .OUT_REG(OREG[k]), .CLEAR_ON_RESET(1)
        ) u_dut (
            .in_clock(clk),
            .in_reset(rst),
            .bus(bus)
        );

        assign obs_dat[k] = bus.out_data;
        assign obs_vld[k] = bus.out_valid;
        assign obs_bsy[k] = bus.out_busy;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory contents, clear edges still owed, and what each variant shows.
    logic [15:0] ref_mem [DEPTH];
    int          clr_rem = 0;
    logic [15:0] res_d [3];
    logic        res_v [3];
    logic [15:0] pre_d [3];
    logic        pre_v [3];

    function automatic void model_edge();
        logic        acc;
        logic [15:0] old;
        logic [15:0] neww;
        if (rst) begin
            clr_rem = DEPTH;
            for (int k = 0; k < 3; k++) begin
                res_d[k] = '0; res_v[k] = 1'b0;
                pre_d[k] = '0; pre_v[k] = 1'b0;
            end
            return;
        end
        acc  = en && (clr_rem == 0);
        old  = ref_mem[addr];
        neww = {be[1] ? wdat[15:8] : old[15:8], be[0] ? wdat[7:0] : old[7:0]};
        for (int k = 0; k < 3; k++) begin
            // With an output register the visible result is the previous edge's result.
            pre_d[k] = res_d[k];
            pre_v[k] = res_v[k];
            if (!acc) begin
                res_v[k] = 1'b0;
            end else if (!wr) begin
                res_d[k] = old; res_v[k] = 1'b1;
            end else begin
                case (MODE[k])
                    0:       begin res_d[k] = old;  res_v[k] = 1'b1; end
                    1:       begin res_d[k] = neww; res_v[k] = 1'b1; end
                    default: res_v[k] = 1'b0;
                endcase
            end
        end
        if (acc && wr) ref_mem[addr] = neww;
        if (clr_rem > 0) begin
            ref_mem[DEPTH - clr_rem] = '0;
            clr_rem--;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_data", k), 32'(obs_dat[k]), 32'(OREG[k] != 0 ? pre_d[k] : res_d[k]));
            check($sformatf("d%0d_valid", k), 32'(obs_vld[k]), 32'(OREG[k] != 0 ? pre_v[k] : res_v[k]));
            check($sformatf("d%0d_busy", k), 32'(obs_bsy[k]), 32'(clr_rem > 0));
        end
    endtask

    task automatic drive(input logic e, input logic w, input logic [1:0] b,
                         input logic [3:0] a, input logic [15:0] d);
        en = e; wr = w; be = b; addr = a; wdat = d;
    endtask

    // Busy cycles counted from reset release, including the period before the first edge.
    task automatic measure_busy(input string tag);
        int n;
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 4'd0, 16'd0);
        n = (obs_bsy[0] === 1'b1) ? 1 : 0;
        for (int i = 0; i < 64; i++) begin
            if (obs_bsy[0] !== 1'b1) break;
            cycle();
            if (obs_bsy[0] === 1'b1) n++;
        end
        check(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 4'd0, 16'd0);
        repeat (3) cycle();
        measure_busy("busy_len");

        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 1'b0, 2'b00, 4'(a), 16'd0);
            cycle();
            check($sformatf("clr_rd%0d", a), 32'(obs_dat[0]), 32'h0);
            check($sformatf("clr_vld%0d", a), 32'(obs_vld[0]), 32'h1);
        end

        drive(1'b1, 1'b1, 2'b11, 4'd5, 16'hAAAA); cycle();
        drive(1'b1, 1'b1, 2'b01, 4'd5, 16'h1234); cycle();
        drive(1'b1, 1'b0, 2'b00, 4'd5, 16'h0);    cycle();
        check("be_lane0", 32'(obs_dat[0]), 32'hAA34);
        drive(1'b1, 1'b1, 2'b00, 4'd5, 16'hFFFF); cycle();
        drive(1'b1, 1'b0, 2'b00, 4'd5, 16'h0);    cycle();
        check("be_none", 32'(obs_dat[0]), 32'hAA34);

        drive(1'b1, 1'b1, 2'b11, 4'd7, 16'h1111); cycle();
        drive(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);    cycle();
        drive(1'b1, 1'b1, 2'b11, 4'd7, 16'h2222); cycle();
        check("rdw0_data", 32'(obs_dat[0]), 32'h1111);
        check("rdw0_vld", 32'(obs_vld[0]), 32'h1);
        check("rdw1_data", 32'(obs_dat[1]), 32'h2222);
        check("rdw1_vld", 32'(obs_vld[1]), 32'h1);
        drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);    cycle();
        check("rdw2_data", 32'(obs_dat[2]), 32'h1111);
        check("rdw2_vld", 32'(obs_vld[2]), 32'h0);

        for (int a = 0; a < 3; a++) begin
            drive(1'b1, 1'b1, 2'b11, 4'(a), 16'(16'h10 + a)); cycle();
        end
        drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0); cycle();
        drive(1'b1, 1'b0, 2'b00, 4'd0, 16'h0); cycle();
        check("pipe_v0", 32'(obs_vld[2]), 32'h0);
        for (int a = 1; a < 4; a++) begin
            drive(a < 3, 1'b0, 2'b00, 4'(a), 16'h0); cycle();
            check($sformatf("pipe_v%0d", a), 32'(obs_vld[2]), 32'h1);
            check($sformatf("pipe_d%0d", a), 32'(obs_dat[2]), 32'(16'h10 + a - 1));
        end
        drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0); cycle();
        check("pipe_end", 32'(obs_vld[2]), 32'h0);

        drive(1'b1, 1'b0, 2'b00, 4'd2, 16'h0); cycle();
        drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0); cycle();
        rst = 1'b1; cycle();
        check("rst_d0", 32'(obs_dat[0]), 32'h0);
        check("rst_v0", 32'(obs_vld[0]), 32'h0);
        check("rst_d2", 32'(obs_dat[2]), 32'h0);
        check("rst_v2", 32'(obs_vld[2]), 32'h0);

        // Write to address 3 on every busy cycle; none may land.
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 2'b11, 4'd3, 16'hBEEF);
            cycle();
            if (obs_bsy[0] !== 1'b1) break;
        end
        check("clear_end", 32'(obs_bsy[0]), 32'h0);
        drive(1'b1, 1'b0, 2'b00, 4'd3, 16'h0); cycle();
        check("busy_drop", 32'(obs_dat[0]), 32'h0);

        rst = 1'b1; drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0); cycle();
        rst = 1'b0; repeat (9) cycle();
        rst = 1'b1; cycle();
        measure_busy("busy_restart");

        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 16'($urandom));
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
